// File: rtl/unified_mem_arb_pkg.sv
// Shared types for the unified memory arbiter: FSM states, requester ids, width defaults.
package unified_mem_arb_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_t;
endpackage

// File: rtl/unified_mem_arb_select.sv
// Combinational arbitration: data wins unless fetch has waited through a full streak.
import unified_mem_arb_pkg::*;

module unified_mem_arb_select #(
  parameter int MAX_D_STREAK = 4,
  parameter int SW           = 3
) (
  input  logic          if_req,
  input  logic          d_req,
  input  logic [SW-1:0] streak,
  output req_id_t       winner,
  output logic          gnt_valid
);
  always_comb begin
    gnt_valid = if_req | d_req;
    winner    = REQ_IF;
    if (d_req && !(if_req && (streak == SW'(MAX_D_STREAK)))) winner = REQ_D;
  end
endmodule

// File: rtl/unified_mem_arbiter.sv
// Two-port arbiter for one single-port memory; one access in flight, fixed read latency.
// Handshake: a req is held stable until its one-cycle gnt; gnt only issues in IDLE, same cycle.
import unified_mem_arb_pkg::*;

module unified_mem_arbiter #(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MEM_LAT      = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t        state;
  req_id_t       owner;
  req_id_t       winner;
  logic          gnt_valid;
  logic          take;
  logic          cap;
  logic          we_q;
  logic [SW-1:0] streak;
  logic [CW-1:0] cnt;

  unified_mem_arb_select #(
    .MAX_D_STREAK(MAX_D_STREAK),
    .SW          (SW)
  ) u_select (
    .if_req   (if_req),
    .d_req    (d_req),
    .streak   (streak),
    .winner   (winner),
    .gnt_valid(gnt_valid)
  );

  // Gating with rst_n keeps the grants low while reset is held.
  assign take   = rst_n && (state == IDLE) && gnt_valid;
  assign if_gnt = take && (winner == REQ_IF);
  assign d_gnt  = take && (winner == REQ_D);
  assign cap    = ((state == ACCESS) && (MEM_LAT == 1)) || ((state == WAIT) && (cnt == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= REQ_IF;
      we_q      <= 1'b0;
      streak    <= '0;
      cnt       <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_done    <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            owner  <= winner;
            mem_en <= 1'b1;
            state  <= ACCESS;
            if (winner == REQ_D) begin
              we_q      <= d_we;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              if (!if_req)                            streak <= '0;
              else if (streak != SW'(MAX_D_STREAK))   streak <= streak + SW'(1);
            end else begin
              we_q     <= 1'b0;
              mem_we   <= 1'b0;
              mem_addr <= if_addr;
              streak   <= '0;
            end
          end
        end
        ACCESS: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (MEM_LAT == 1) begin
            state <= RESP;
          end else begin
            cnt   <= CW'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - CW'(1);
        end
        RESP: begin
          if_rvalid <= 1'b0;
          d_done    <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Read data is sampled on the edge that ends the last latency cycle.
      if (cap) begin
        if (owner == REQ_IF) begin
          if_rvalid <= 1'b1;
          if_rdata  <= mem_rdata;
        end else begin
          d_done <= 1'b1;
          if (!we_q) d_rdata <= mem_rdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: transaction-level reference model, directed steps and random traffic.
module tb_unified_mem_arbiter;
  localparam int AW   = 10;
  localparam int DW   = 16;
  localparam int LAT  = 3;
  localparam int MAXS = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // MEM_LAT=3 instance
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] d_wdata, if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic          if_gnt, if_rvalid, d_gnt, d_done, mem_en, mem_we;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_D_STREAK(MAXS)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // memory: data for an access is presented during the last latency cycle
  logic [DW-1:0] mem  [1024];
  logic [DW-1:0] pipe [LAT-1];
  always @(posedge clk) begin
    pipe[0] <= mem_en ? mem[mem_addr] : 'x;
    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = pipe[LAT-2];

  // MEM_LAT=1 instance
  logic          a_if_req, a_d_req, a_d_we;
  logic [AW-1:0] a_if_addr, a_d_addr, a_mem_addr;
  logic [DW-1:0] a_d_wdata, a_if_rdata, a_d_rdata, a_mem_wdata, a_mem_rdata;
  logic          a_if_gnt, a_if_rvalid, a_d_gnt, a_d_done, a_mem_en, a_mem_we;
  logic [DW-1:0] mem1 [1024];

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .MAX_D_STREAK(MAXS)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_gnt(a_d_gnt), .d_done(a_d_done), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );
  assign a_mem_rdata = a_mem_en ? mem1[a_mem_addr] : 'x;

  // scoreboard / reference model
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            acc_cyc = -1, resp_cyc = -1, free_cyc = 0;
  int            m_streak = 0;
  bit            m_port, m_we, e_if_gnt, e_d_gnt;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_data, m_if_rdata, m_d_rdata;
  logic [DW-1:0] ref_mem [1024];
  logic [0:0]    got_q[$];
  logic [0:0]    exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {if_gnt, if_rvalid, if_rdata, d_gnt, d_done, d_rdata,
              mem_en, mem_we, mem_addr, mem_wdata}, 64'h0);
  endtask

  task automatic model_reset();
    acc_cyc = -1; resp_cyc = -1; free_cyc = cyc; m_streak = 0;
    m_if_rdata = '0; m_d_rdata = '0;
  endtask

  // one clock cycle: entered just after a negedge with inputs set, leaves at the next negedge
  task automatic cycle();
    bit win_d;
    #1;
    e_if_gnt = 1'b0;
    e_d_gnt  = 1'b0;
    if (cyc >= free_cyc && (if_req || d_req)) begin
      win_d = d_req && !(if_req && m_streak == MAXS);
      if (win_d) begin
        e_d_gnt  = 1'b1;
        m_streak = if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
        m_port = 1'b1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
        if (d_we) ref_mem[d_addr] = d_wdata;
        else      m_data = ref_mem[d_addr];
      end else begin
        e_if_gnt = 1'b1;
        m_streak = 0;
        m_port = 1'b0; m_we = 1'b0; m_addr = if_addr;
        m_data = ref_mem[if_addr];
      end
      acc_cyc  = cyc + 1;
      resp_cyc = cyc + 1 + LAT;
      free_cyc = cyc + 2 + LAT;
    end
    chk("if_gnt", if_gnt, e_if_gnt);
    chk("d_gnt", d_gnt, e_d_gnt);
    if (if_gnt) got_q.push_back(1'b0);
    if (d_gnt)  got_q.push_back(1'b1);
    chk("mem_en", mem_en, cyc == acc_cyc);
    if (cyc == acc_cyc) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", mem_we, m_we);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end else begin
      chk("mem_we_off", mem_we, 1'b0);
    end
    if (cyc == resp_cyc) begin
      if (!m_port)   m_if_rdata = m_data;
      else if (!m_we) m_d_rdata = m_data;
    end
    chk("if_rvalid", if_rvalid, (cyc == resp_cyc) && !m_port);
    chk("d_done", d_done, (cyc == resp_cyc) && m_port);
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("d_rdata", d_rdata, m_d_rdata);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic wait_grants(input int n, input string tag);
    int k = 0;
    got_q.delete();
    while (got_q.size() < n && k < 200) begin
      cycle();
      k++;
    end
    chk({tag, "_grant_timeout"}, got_q.size() >= n, 1'b1);
  endtask

  task automatic cmp_seq(input string tag);
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_gnt%0d", tag, i), (i < got_q.size()) ? got_q[i] : 1'bx, exp_q[i]);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = DW'($urandom);
      ref_mem[i] = mem[i];
      mem1[i]    = DW'($urandom);
    end
    mem1[3] = 16'hE100;
    if_req = 1'b1; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    a_if_req = 1'b0; a_if_addr = '0; a_d_req = 1'b0; a_d_we = 1'b0; a_d_addr = '0; a_d_wdata = '0;
    m_if_rdata = '0; m_d_rdata = '0;

    // reset with a request pending: everything stays low
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 chk_zero("reset_state");
    chk("reset_dut1", {a_if_gnt, a_if_rvalid, a_if_rdata, a_mem_en, a_mem_addr}, 64'h0);
    if_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // write 510 then read it back
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'd510; d_wdata = 16'h1234;
    wait_grants(1, "wr");
    d_req = 1'b0;
    idle(6);
    d_req = 1'b1; d_we = 1'b0;
    wait_grants(1, "rd");
    d_req = 1'b0;
    idle(6);
    chk("rd_510", d_rdata, 16'h1234);
    chk("if_rdata_untouched", if_rdata, 16'h0);

    // continuous contention
    if_req = 1'b1; if_addr = 10'd7; d_req = 1'b1; d_we = 1'b0; d_addr = 10'd9;
    wait_grants(10, "cont");
    exp_q.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back((i % 5 == 4) ? 1'b0 : 1'b1);
    cmp_seq("cont");

    // uncontended data grants clear the streak
    wait_grants(2, "pre");
    if_req = 1'b0;
    wait_grants(2, "solo");
    if_req = 1'b1;
    wait_grants(5, "streak");
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back((i == 4) ? 1'b0 : 1'b1);
    cmp_seq("streak");
    if_req = 1'b0; d_req = 1'b0;
    idle(6);

    // data request withdrawn while a fetch is in flight
    if_req = 1'b1; if_addr = 10'd3;
    wait_grants(1, "wd_fetch");
    if_req = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'd20; d_wdata = 16'hBEEF;
    cycle();
    d_req = 1'b0;
    got_q.delete();
    idle(8);
    chk("withdraw_no_gnt", got_q.size(), 0);

    // reset during WAIT abandons the access
    if_req = 1'b1; if_addr = 10'd5;
    wait_grants(1, "rst_fetch");
    if_req = 1'b0;
    cycle();
    rst_n = 1'b0;
    #1 chk_zero("rst_mid_now");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      #1 chk_zero($sformatf("rst_mid_hold%0d", k));
    end
    if_req = 1'b1; if_addr = 10'd6; rst_n = 1'b1;
    model_reset();
    cycle();
    chk("rst_first_idle_gnt", e_if_gnt, 1'b1);
    if_req = 1'b0;
    idle(8);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = AW'($urandom_range(0, 15));
      end else if (if_req && $urandom_range(0, 15) == 0) begin
        if_req = 1'b0;
      end
      if (!d_req && $urandom_range(0, 1) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom); d_addr = AW'($urandom_range(0, 15)); d_wdata = DW'($urandom);
      end else if (d_req && $urandom_range(0, 15) == 0) begin
        d_req = 1'b0;
      end
      cycle();
      if (e_if_gnt) if_req = 1'b0;
      if (e_d_gnt)  d_req  = 1'b0;
    end
    if_req = 1'b0; d_req = 1'b0;
    idle(6);

    // single fetch on the MEM_LAT=1 instance; request held to see the next grant
    a_if_req = 1'b1; a_if_addr = 10'd3;
    #1 chk("l1_c0_gnt", a_if_gnt, 1'b1);
    chk("l1_c0_mem_en", a_mem_en, 1'b0);
    @(posedge clk); @(negedge clk); #1;
    chk("l1_c1_gnt", a_if_gnt, 1'b0);
    chk("l1_c1_mem", {a_mem_en, a_mem_we, a_mem_addr}, {1'b1, 1'b0, 10'd3});
    chk("l1_c1_rvalid", a_if_rvalid, 1'b0);
    @(posedge clk); @(negedge clk); #1;
    chk("l1_c2_gnt", a_if_gnt, 1'b0);
    chk("l1_c2_mem_en", a_mem_en, 1'b0);
    chk("l1_c2_rvalid", a_if_rvalid, 1'b1);
    chk("l1_c2_rdata", a_if_rdata, 16'hE100);
    @(posedge clk); @(negedge clk); #1;
    chk("l1_c3_gnt", a_if_gnt, 1'b1);
    chk("l1_c3_rvalid", a_if_rvalid, 1'b0);
    chk("l1_c3_rdata_hold", a_if_rdata, 16'hE100);
    a_if_req = 1'b0;
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
